// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and constants for the serial register-file controller.
// Holds the FSM state encoding and the default data word width.
package reg_file_ctrl_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the priority holder, and every acceptance hands priority to the other side.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic r_prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prio <= 1'b0;
        end else if (accept) begin
            r_prio <= gnt[0];
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Arbitrates two requesters onto a bit-serial register-file port: writes are
// shifted out LSB first, reads are shifted in and returned as a one-cycle strobe.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     REQ_VALID,
    input  logic [1:0]     REQ_WR,
    input  logic [2*W-1:0] REQ_WDATA,
    output logic [1:0]     REQ_READY,
    output logic [1:0]     RSP_VALID,
    output logic [W-1:0]   RSP_RDATA,
    output logic           RF_WR_EN,
    output logic           RF_RD_EN,
    output logic           RF_DIN,
    input  logic           RF_DOUT,
    output state_t         DBG_STATE
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Handshake: a requester holds VALID and its payload until it sees READY;
    // the transfer happens on the rising edge where VALID and READY are both high.

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_wdata;
    logic [W-2:0]   r_shift;
    logic [W-1:0]   r_rdata;
    logic           r_id;
    logic           r_wr_en;
    logic           r_rd_en;
    logic           r_din;
    logic [1:0]     r_rsp_valid;

    logic [1:0]     w_gnt;
    logic           w_idle;
    logic           w_accept;
    logic           w_sel;
    logic [W-1:0]   w_wdata_sel;
    logic [CW-1:0]  w_cnt_inc;

    assign w_idle      = (r_state == ST_IDLE);
    assign REQ_READY   = w_idle ? w_gnt : 2'b00;
    assign w_accept    = |(REQ_VALID & REQ_READY);
    assign w_sel       = w_gnt[1];
    assign w_wdata_sel = w_sel ? REQ_WDATA[2*W-1:W] : REQ_WDATA[W-1:0];
    assign w_cnt_inc   = r_cnt + CW'(1);

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    (REQ_VALID),
        .accept (w_accept),
        .gnt    (w_gnt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_rdata     <= '0;
            r_id        <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_din       <= 1'b0;
            r_rsp_valid <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_sel;
                        r_cnt <= '0;
                        if (REQ_WR[w_sel]) begin
                            r_state <= ST_WRITE;
                            r_wdata <= w_wdata_sel;
                            r_wr_en <= 1'b1;
                            r_din   <= w_wdata_sel[0];
                        end else begin
                            r_state <= ST_READ;
                            r_rd_en <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_wr_en <= 1'b0;
                        r_din   <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_din   <= r_wdata[1];
                        r_wdata <= r_wdata >> 1;
                    end
                end

                ST_READ: begin
                    // RF_DOUT lags RF_RD_EN by one cycle, so bit k arrives at count k+1.
                    if (r_cnt != '0) begin
                        r_shift[r_cnt - CW'(1)] <= RF_DOUT;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RDWAIT;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                ST_RDWAIT: begin
                    r_rdata     <= {RF_DOUT, r_shift};
                    r_rsp_valid <= id_onehot(r_id);
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    r_rsp_valid <= 2'b00;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_wr_en     <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_din       <= 1'b0;
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rdata;
    assign RF_WR_EN  = r_wr_en;
    assign RF_RD_EN  = r_rd_en;
    assign RF_DIN    = r_din;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: a cycle-indexed schedule model predicts every output
// from the transfer rules; directed scenarios plus randomized traffic with resets.
module tb_reg_file_ctrl;
    import reg_file_ctrl_pkg::*;

    localparam int W    = 8;
    localparam int MAXC = 8192;

    logic           CLK = 1'b0;
    logic           RST;
    logic [1:0]     REQ_VALID;
    logic [1:0]     REQ_WR;
    logic [2*W-1:0] REQ_WDATA;
    logic [1:0]     REQ_READY;
    logic [1:0]     RSP_VALID;
    logic [W-1:0]   RSP_RDATA;
    logic           RF_WR_EN;
    logic           RF_RD_EN;
    logic           RF_DIN;
    logic           RF_DOUT;
    state_t         DBG_STATE;

    reg_file_ctrl #(.W(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_WR    (REQ_WR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_READY (REQ_READY),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RF_WR_EN  (RF_WR_EN),
        .RF_RD_EN  (RF_RD_EN),
        .RF_DIN    (RF_DIN),
        .RF_DOUT   (RF_DOUT),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model state ----------------
    typedef struct {
        bit           wr;
        logic [W-1:0] data;   // write word, or the word the register file returns for a read
        int           gap;
        int           rst_off;
    } txn_t;

    typedef struct { int cyc; int id; } acc_t;
    typedef struct { int cyc; logic [1:0] v; logic [W-1:0] d; } rsp_t;

    txn_t q0[$];
    txn_t q1[$];
    int   rdy_at[2];

    bit        e_wr   [MAXC];
    bit        e_din  [MAXC];
    bit        e_rd   [MAXC];
    bit [1:0]  e_rspv [MAXC];
    bit [W-1:0] e_rdata[MAXC];
    bit        dout_s [MAXC];

    logic [W-1:0] exp_q[$];

    int           cyc;
    int           m_free;
    int           m_prio;
    logic [W-1:0] m_rdata;
    int           m_rsp_due;
    int           rst_at;

    acc_t         acc_log[$];
    rsp_t         rsp_log[$];
    logic [W-1:0] cap_w;
    int           cap_n;
    int           rd_n;

    int n_chk;
    int n_err;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic int pick(input logic [1:0] v, input int prio);
        if (v == 2'b11) return prio;
        if (v[1]) return 1;
        return 0;
    endfunction

    task automatic push_txn(input int id, input bit wr, input logic [W-1:0] data,
                            input int gap, input int rst_off);
        txn_t t;
        t.wr = wr; t.data = data; t.gap = gap; t.rst_off = rst_off;
        if (id == 0) begin
            if (q0.size() == 0) rdy_at[0] = cyc + 1 + gap;
            q0.push_back(t);
        end else begin
            if (q1.size() == 0) rdy_at[1] = cyc + 1 + gap;
            q1.push_back(t);
        end
    endtask

    task automatic model_accept(input int id);
        txn_t t;
        if (id == 0) begin
            t = q0.pop_front();
            if (q0.size() > 0) rdy_at[0] = cyc + 1 + q0[0].gap;
        end else begin
            t = q1.pop_front();
            if (q1.size() > 0) rdy_at[1] = cyc + 1 + q1[0].gap;
        end
        m_prio = 1 - id;
        if (t.wr) begin
            for (int k = 0; k < W; k++) begin
                e_wr[cyc + 1 + k]  = 1'b1;
                e_din[cyc + 1 + k] = t.data[k];
            end
            m_free = cyc + W + 1;
        end else begin
            for (int k = 0; k < W; k++) begin
                e_rd[cyc + 1 + k]   = 1'b1;
                dout_s[cyc + 2 + k] = t.data[k];
            end
            e_rspv[cyc + W + 2]  = (id == 0) ? 2'b01 : 2'b10;
            e_rdata[cyc + W + 2] = t.data;
            exp_q.push_back(t.data);
            m_rsp_due = cyc + W + 2;
            m_free    = cyc + W + 3;
        end
        if (t.rst_off > 0) rst_at = cyc + t.rst_off;
    endtask

    task automatic model_reset();
        for (int c = cyc + 1; c < cyc + W + 4; c++) begin
            e_wr[c] = 1'b0; e_din[c] = 1'b0; e_rd[c] = 1'b0; e_rspv[c] = 2'b00;
        end
        if (m_rsp_due > cyc && exp_q.size() > 0) void'(exp_q.pop_back());
        m_rsp_due = -1;
        m_free    = cyc + 1;
        m_prio    = 0;
        m_rdata   = '0;
        rst_at    = -1;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step();
        logic [1:0]     v;
        logic [1:0]     w;
        logic [1:0]     eg;
        logic [2*W-1:0] wd;
        bit             rst_now;
        acc_t           a;
        rsp_t           r;
        @(posedge CLK);
        cyc++;
        #1;
        rst_now = (rst_at == cyc);
        v = 2'b00; w = 2'b00; wd = '0;
        if (q0.size() > 0) begin
            w[0] = q0[0].wr; wd[W-1:0] = q0[0].data;
            if (!rst_now && cyc >= rdy_at[0]) v[0] = 1'b1;
        end
        if (q1.size() > 0) begin
            w[1] = q1[0].wr; wd[2*W-1:W] = q1[0].data;
            if (!rst_now && cyc >= rdy_at[1]) v[1] = 1'b1;
        end
        RST       = rst_now;
        REQ_VALID = v;
        REQ_WR    = w;
        REQ_WDATA = wd;
        RF_DOUT   = dout_s[cyc];
        if (e_rspv[cyc] != 2'b00) m_rdata = e_rdata[cyc];
        eg = 2'b00;
        if (!rst_now && cyc >= m_free && v != 2'b00) eg = 2'(1 << pick(v, m_prio));

        @(negedge CLK);
        if (!rst_now) check("req_ready", REQ_READY, eg);
        check("rf_wr_en",  RF_WR_EN,  e_wr[cyc]);
        check("rf_din",    RF_DIN,    e_din[cyc]);
        check("rf_rd_en",  RF_RD_EN,  e_rd[cyc]);
        check("rsp_valid", RSP_VALID, e_rspv[cyc]);
        check("rsp_rdata", RSP_RDATA, m_rdata);

        if (RSP_VALID != 2'b00) begin
            r.cyc = cyc; r.v = RSP_VALID; r.d = RSP_RDATA;
            rsp_log.push_back(r);
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_word", RSP_RDATA, exp_q.pop_front());
        end
        if (RF_WR_EN) begin
            cap_w = {RF_DIN, cap_w[W-1:1]};
            cap_n++;
        end
        if (RF_RD_EN) rd_n++;
        if (!rst_now && (REQ_VALID & REQ_READY) != 2'b00) begin
            a.cyc = cyc; a.id = REQ_READY[1] ? 1 : 0;
            acc_log.push_back(a);
        end

        if (rst_now) model_reset();
        else if (eg != 2'b00) model_accept(eg[1] ? 1 : 0);
    endtask

    task automatic run_phase(input int budget);
        int start;
        start = cyc;
        while (q0.size() > 0 || q1.size() > 0 || cyc < m_free || rst_at >= 0) begin
            if (cyc - start > budget) begin
                check("phase_timeout", 1, 0);
                break;
            end
            step();
        end
        step();
    endtask

    task automatic clear_logs();
        acc_log.delete();
        rsp_log.delete();
        cap_w = '0;
        cap_n = 0;
        rd_n  = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int t0;
        bit wr;
        n_chk = 0; n_err = 0;
        cyc = 0; m_free = 0; m_prio = 0; m_rdata = '0; m_rsp_due = -1; rst_at = -1;
        rdy_at[0] = 0; rdy_at[1] = 0;
        for (int c = 0; c < MAXC; c++) dout_s[c] = 1'($urandom_range(0, 1));

        RST = 1'b1; REQ_VALID = 2'b00; REQ_WR = 2'b00; REQ_WDATA = '0; RF_DOUT = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_state",     DBG_STATE, ST_IDLE);
        check("rst_ready",     REQ_READY, 2'b00);
        check("rst_wr_en",     RF_WR_EN,  1'b0);
        check("rst_rd_en",     RF_RD_EN,  1'b0);
        check("rst_din",       RF_DIN,    1'b0);
        check("rst_rsp_valid", RSP_VALID, 2'b00);
        check("rst_rsp_rdata", RSP_RDATA, '0);

        // req0 writes A5 alone
        clear_logs();
        push_txn(0, 1'b1, 8'hA5, 0, 0);
        run_phase(100);
        check("a5_bits", cap_w, 8'hA5);
        check("a5_len",  cap_n, W);
        check("a5_rsp",  rsp_log.size(), 0);

        // req1 reads, register file returns 3C
        clear_logs();
        push_txn(1, 1'b0, 8'h3C, 0, 0);
        run_phase(100);
        check("rd_len",  rd_n, W);
        check("rd_nacc", acc_log.size(), 1);
        check("rd_nrsp", rsp_log.size(), 1);
        if (acc_log.size() == 1 && rsp_log.size() == 1) begin
            check("rd_acc_id", acc_log[0].id, 1);
            check("rd_rsp_v",  rsp_log[0].v, 2'b10);
            check("rd_rsp_d",  rsp_log[0].d, 8'h3C);
            check("rd_rsp_t",  rsp_log[0].cyc - acc_log[0].cyc, W + 2);
        end

        // after reset, both requesters stream writes
        clear_logs();
        rst_at = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            push_txn(0, 1'b1, W'($urandom), 0, 0);
            push_txn(1, 1'b1, W'($urandom), 0, 0);
        end
        run_phase(200);
        check("rr_nacc", acc_log.size(), 8);
        for (int i = 0; i < acc_log.size(); i++) begin
            check("rr_id", acc_log[i].id, i % 2);
            if (i > 0) check("rr_gap", acc_log[i].cyc - acc_log[i-1].cyc, W + 1);
        end

        // req0 alone, back-to-back writes
        clear_logs();
        for (int i = 0; i < 4; i++) push_txn(0, 1'b1, W'($urandom), 0, 0);
        run_phase(200);
        check("solo_nacc", acc_log.size(), 4);
        for (int i = 0; i < acc_log.size(); i++) begin
            check("solo_id", acc_log[i].id, 0);
            if (i > 0) check("solo_gap", acc_log[i].cyc - acc_log[i-1].cyc, W + 1);
        end

        // reset lands on read bit 4; priority must restart at req0
        clear_logs();
        push_txn(0, 1'b0, 8'h5A, 0, 5);
        push_txn(0, 1'b1, 8'h81, 0, 0);
        push_txn(1, 1'b1, 8'h7E, 3, 0);
        run_phase(200);
        check("abort_nrsp", rsp_log.size(), 0);
        check("abort_nacc", acc_log.size(), 3);
        if (acc_log.size() >= 2) begin
            t0 = acc_log[0].cyc;
            check("abort_next_id", acc_log[1].id, 0);
            check("abort_next_t",  acc_log[1].cyc - t0, 6);
        end

        // randomized mixed traffic with occasional mid-operation resets
        clear_logs();
        for (int i = 0; i < 25; i++) begin
            for (int id = 0; id < 2; id++) begin
                wr = 1'($urandom_range(0, 1));
                push_txn(id, wr, W'($urandom), $urandom_range(0, 3),
                         ($urandom_range(0, 9) == 0) ? $urandom_range(1, wr ? W : W + 2) : 0);
            end
        end
        run_phase(3000);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 Parameter W, default 8: data word width in bits (W >= 2).
REQ-002 Port CLK  input  1  system clock, all logic on rising edge.
REQ-003 Port RST  input  1  reset, synchronous, active-high.
REQ-004 Port REQ_VALID  input  2  per-requester request valid; requester holds VALID and payload stable until accepted.
REQ-005 Port REQ_WR  input  2  per-requester op: 1 = write, 0 = read.
REQ-006 Port REQ_WDATA  input  2xW  per-requester write word.
REQ-007 Port REQ_READY  output  2  per-requester accept; transfer occurs when VALID and READY are both high.
REQ-008 Port RSP_VALID  output  2  one-hot read-response strobe, one cycle, no backpressure.
REQ-009 Port RSP_RDATA  output  W  read word, valid while any RSP_VALID bit is high.
REQ-010 Port RF_WR_EN  output  1  register-file serial write enable.
REQ-011 Port RF_RD_EN  output  1  register-file serial read enable.
REQ-012 Port RF_DIN  output  1  serial write bit.
REQ-013 Port RF_DOUT  input  1  serial read bit, valid one cycle after the corresponding RF_RD_EN cycle.

Function
REQ-014 FSM states SHALL be IDLE, WRITE, READ, RDWAIT and RESP.
REQ-015 REQ_READY SHALL be nonzero only in IDLE and SHALL be one-hot, selecting the arbitration winner among valid requesters.
REQ-016 Arbitration SHALL be two-way round-robin: a sole valid requester always wins; when both are valid, the priority holder wins; after every acceptance, priority passes to the other requester.
REQ-017 Write accepted in cycle T: RF_WR_EN SHALL be high in cycles T+1..T+W, with RF_DIN = WDATA[k] in cycle T+1+k (LSB first).
REQ-018 Read accepted in cycle T: RF_RD_EN SHALL be high in cycles T+1..T+W, and RF_DOUT sampled in cycle T+2+k SHALL become RSP_RDATA[k].
REQ-019 Read response: RSP_VALID[granted] SHALL be high in cycle T+W+2 only, with the full word on RSP_RDATA.
REQ-020 FSM SHALL return to IDLE so that the next acceptance can occur at T+W+1 after a write and at T+W+3 after a read.
REQ-021 RF_WR_EN and RF_RD_EN SHALL never be high in the same cycle.
REQ-022 RF_DIN SHALL be 0 whenever RF_WR_EN is low.
REQ-023 RSP_RDATA SHALL hold its last value outside RSP_VALID.
REQ-024 The bit counter SHALL be clog2(W) wide and SHALL terminate at W-1 without wrap.
REQ-025 All outputs SHALL be registered except REQ_READY, which is combinational from state, priority and REQ_VALID.

Reset
REQ-026 RST high SHALL force IDLE, priority to requester 0, counter 0, and all outputs 0 on the next edge, including RSP_RDATA = 0.
REQ-027 RST during WRITE, READ, RDWAIT or RESP SHALL abort the operation with no RSP_VALID pulse; no RF enable SHALL be asserted in the cycle after reset is sampled.

Structure
REQ-028 Package reg_file_ctrl_pkg SHALL hold the FSM state enum and the default W constant.
REQ-029 Arbitration SHALL be a sub-module rr_arb2: inputs CLK, RST, req[1:0] and accept; output gnt[1:0] one-hot; it holds the priority flop.

Verification
REQ-030 Req0 writes 8'hA5 accepted at T -> RF_WR_EN high T+1..T+8, RF_DIN = 1,0,1,0,0,1,0,1, no RSP_VALID.
REQ-031 Req1 reads accepted at T, RF model returns 8'h3C -> RF_RD_EN high T+1..T+8, RSP_VALID = 2'b10 and RSP_RDATA = 8'h3C at T+10 only.
REQ-032 After reset, both requesters valid continuously with writes -> grants 0,1,0,1, acceptances 9 cycles apart.
REQ-033 Req1 idle, req0 issues back-to-back writes -> req0 granted every time, 9-cycle spacing.
REQ-034 RST asserted during read bit 4 -> next cycle all outputs 0, no RSP_VALID, next request granted to req0.
